// File: rtl/layer_4_maxpool2x2_pkg.sv
// Shared layer datapath definitions: fp32 width, fp32 ordering key and
// pooling size helper used by the layer-4 max-pool stage.
package layer_4_maxpool2x2_pkg;

  localparam int FP32_WIDTH = 32;

  typedef logic [FP32_WIDTH-1:0] fp32_t;

  // Maps fp32 bit patterns onto unsigned integers that sort in numeric order
  // (negatives inverted, positives offset above them), so -0 sorts below +0.
  function automatic fp32_t fp32_key(input fp32_t x);
    fp32_t r_key;
    if (x[FP32_WIDTH-1]) begin
      r_key = ~x;
    end else begin
      r_key = x ^ {1'b1, {(FP32_WIDTH-1){1'b0}}};
    end
    return r_key;
  endfunction

  function automatic int pool_out_size(input int img_size);
    return img_size / 2;
  endfunction

endpackage

// File: rtl/layer_4_maxpool2x2_fp32_max.sv
// Combinational two-input fp32 maximum using the ordering key; on equal keys
// the first operand is returned.
module fp32_max
  import layer_4_maxpool2x2_pkg::*;
(
  input  logic [FP32_WIDTH-1:0] i_a,
  input  logic [FP32_WIDTH-1:0] i_b,
  output logic [FP32_WIDTH-1:0] o_max
);

  logic [FP32_WIDTH-1:0] w_key_a;
  logic [FP32_WIDTH-1:0] w_key_b;

  assign w_key_a = fp32_key(i_a);
  assign w_key_b = fp32_key(i_b);
  assign o_max   = (w_key_b > w_key_a) ? i_b : i_a;

endmodule

// File: rtl/layer_4_maxpool2x2.sv
// Streaming 2x2 / stride-2 fp32 max-pool for one channel: horizontal pairs are
// reduced on even rows into a half-width line buffer, finished on odd rows.
module layer_4_maxpool2x2
  import layer_4_maxpool2x2_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  last_out
);

  localparam int OUT_SIZE = pool_out_size(IMG_SIZE);
  localparam int CNT_W    = $clog2(IMG_SIZE);
  localparam int LB_AW    = CNT_W - 1;

  generate
    if ((IMG_SIZE % 2) != 0 || IMG_SIZE < 4) begin : g_bad_img_size
      $error("layer_4_maxpool2x2: IMG_SIZE must be even and at least 4");
    end
    if (DATA_WIDTH != FP32_WIDTH) begin : g_bad_data_width
      $error("layer_4_maxpool2x2: DATA_WIDTH must equal FP32_WIDTH");
    end
  endgenerate

  logic [CNT_W-1:0]      r_col;
  logic [CNT_W-1:0]      r_row;
  logic [DATA_WIDTH-1:0] r_pair;
  logic [DATA_WIDTH-1:0] r_linebuf [OUT_SIZE];

  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_wr_en;
  logic                  w_emit;
  logic [LB_AW-1:0]      w_lb_addr;
  logic [DATA_WIDTH-1:0] w_lb_rd;
  logic [DATA_WIDTH-1:0] w_h_max;
  logic [DATA_WIDTH-1:0] w_v_max;

  assign w_col_last = (r_col == CNT_W'(IMG_SIZE - 1));
  assign w_row_last = (r_row == CNT_W'(IMG_SIZE - 1));
  assign w_lb_addr  = r_col[CNT_W-1:1];

  // Even rows only write the buffer, odd rows only read it.
  assign w_wr_en = valid_in & r_col[0] & ~r_row[0];
  assign w_emit  = valid_in & r_col[0] &  r_row[0];

  assign w_lb_rd = r_linebuf[w_lb_addr];

  fp32_max u_hmax (
    .i_a   (r_pair),
    .i_b   (data_in),
    .o_max (w_h_max)
  );

  fp32_max u_vmax (
    .i_a   (w_lb_rd),
    .i_b   (w_h_max),
    .o_max (w_v_max)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : (r_row + CNT_W'(1));
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pair <= '0;
    end else if (valid_in && !r_col[0]) begin
      r_pair <= data_in;
    end
  end

  // No reset: every entry is rewritten on an even row before its odd-row read.
  always_ff @(posedge Clk) begin
    if (w_wr_en) begin
      r_linebuf[w_lb_addr] <= w_h_max;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      valid_out <= w_emit;
      last_out  <= w_emit & w_col_last & w_row_last;
      if (w_emit) begin
        data_out <= w_v_max;
      end
    end
  end

endmodule

// File: doc/layer_4_maxpool2x2.md
Name: layer_4_maxpool2x2

Overview:
- Streaming 2x2 / stride-2 max-pool stage for one feature-map channel.
- Sits directly downstream of a layer-4 feature-map convolution stage (after its bias/activation output).
- Consumes a raster-order fp32 pixel stream of IMG_SIZE x IMG_SIZE and produces an (IMG_SIZE/2) x (IMG_SIZE/2) raster stream.
- One instance per output channel; no backpressure, valid-only protocol as used throughout the layer datapath.

Parameters:
- DATA_WIDTH, 32, pixel width (IEEE-754 single).
- IMG_SIZE, 104, input width and height in pixels; must be even (elaboration-time error otherwise).

Ports:
- Clk  in  1  clock, all state on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  input pixel, fp32.
- valid_in  in  1  data_in is valid this cycle; at most one pixel per cycle; gaps allowed.
- data_out  out  DATA_WIDTH  pooled pixel, fp32.
- valid_out  out  1  one-cycle pulse per pooled pixel.
- last_out  out  1  asserted with valid_out on the final pooled pixel of a frame.

Behaviour:
- Reset (Rst low, async): col/row counters = 0; pair register = 0; data_out = 0; valid_out = 0; last_out = 0. Line buffer contents are don't-care and are never read before being rewritten.
- Counters:
  - col counts accepted pixels 0..IMG_SIZE-1; row counts 0..IMG_SIZE-1.
  - Both advance only on valid_in. col wraps to 0 and row increments at col = IMG_SIZE-1.
  - At the last pixel of the frame, row wraps to 0 and the next frame starts with no gap required.
- Compare rule:
  - max(a,b) uses an ordering key: key = ~x if sign bit set, else x ^ 0x8000_0000; the larger unsigned key wins.
  - Consequences: -0 < +0; equal keys return a; NaNs are not expected and need no special handling.
- Even col (col[0]=0): store data_in into the pair register.
- Odd col, even row: h = max(pair, data_in); write h to line buffer entry col>>1 (depth IMG_SIZE/2, DATA_WIDTH wide).
- Odd col, odd row:
  - h = max(pair, data_in); result = max(linebuf[col>>1], h).
  - Register result to data_out; valid_out = 1 on the next cycle.
  - last_out = 1 when row = IMG_SIZE-1 and col = IMG_SIZE-1.
- Latency: 1 cycle from the accepting edge of the bottom-right pixel of each 2x2 window to the valid_out pulse.
- Output timing:
  - valid_out and last_out are 0 in every other cycle.
  - data_out holds its last value when valid_out = 0.
- Throughput: one output per four inputs; sustains valid_in high every cycle.
- Line buffer: one read and one write per cycle at most, never to the same entry in the same cycle (writes on even rows, reads on odd rows). Inferable as a simple dual-port RAM or register array.
- valid_in low: no state changes; the output pulse from the previous cycle still completes.
- Reset mid-frame: stream restarts at pixel (0,0) on the first valid_in after reset release; no output is produced for the partial frame.

Decomposition:
- Shared package (layer datapath package):
  - FP32_WIDTH = 32.
  - fp32 ordering-key function.
  - Helper for max-pool output size (IMG_SIZE/2).
- One sub-module: fp32_max, combinational two-input max using the key rule; instantiated twice (horizontal and vertical compare).
- Counters, pair register and line buffer stay in the top module.

Test Plan:
- IMG_SIZE=4, input pixels 1.0..16.0 (0x3F800000..0x41800000) raster, valid every cycle -> outputs 6.0, 8.0, 14.0, 16.0; last_out only on 16.0; each output 1 cycle after input pixels 6, 8, 14, 16.
- IMG_SIZE=4, all pixels negative (-1.0..-16.0) -> outputs -1.0, -3.0, -9.0, -11.0, confirming sign-aware compare.
- Window {+0 (0x00000000), -0 (0x80000000), -0, -0} -> output 0x00000000; window with equal values 0x3F800000 in all four -> output 0x3F800000.
- Random valid_in gaps (about 50% duty), IMG_SIZE=104, random fp32 -> output stream bit-matches a reference model; 2704 outputs per frame; exactly one last_out.
- Two back-to-back frames without idle -> second frame results are independent of the first (line buffer reuse correct); last_out pulses once per frame.
- Assert Rst low at pixel 50 of row 3, release, then send a full frame -> no output before the new frame's first window completes; results correct for the new frame.
